// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcodes, CLFZN flag positions, FSM states.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_ADDC = 4'd1,
    OP_SUB  = 4'd2,
    OP_SUBC = 4'd3,
    OP_CMP  = 4'd4,
    OP_AND  = 4'd5,
    OP_OR   = 4'd6,
    OP_XOR  = 4'd7,
    OP_NOT  = 4'd8,
    OP_MOV  = 4'd9,
    OP_LSH  = 4'd10,
    OP_RSH  = 4'd11,
    OP_ARSH = 4'd12
  } op_e;

  localparam int FLAG_C = 4;
  localparam int FLAG_L = 3;
  localparam int FLAG_F = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_addsub.sv
// Shared adder/subtractor; in subtract mode cin is a borrow-in and cout a borrow-out.
module alu_addsub #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] w_b;
  logic             w_c0;
  logic [WIDTH:0]   w_full;

  // a - b - borrow == a + ~b + ~borrow
  assign w_b    = sub ? ~b : b;
  assign w_c0   = sub ? ~cin : cin;
  assign w_full = {1'b0, a} + {1'b0, w_b} + {{WIDTH{1'b0}}, w_c0};
  assign sum    = w_full[WIDTH-1:0];
  assign cout   = sub ? ~w_full[WIDTH] : w_full[WIDTH];
  assign ovf    = (a[WIDTH-1] == w_b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with persistent CLFZN flags and bit-serial variable shifts.
module alu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [4:0]       flags
);

  state_e             r_state;
  logic [WIDTH-1:0]   r_result;
  logic [WIDTH-1:0]   r_work;
  logic [4:0]         r_flags;
  logic [SHAMT_W-1:0] r_cnt;
  logic [3:0]         r_shop;

  logic               w_accept;
  logic [SHAMT_W-1:0] w_k;
  logic               w_is_shift;
  logic               w_long;
  logic               w_sub;
  logic               w_cin;
  logic [WIDTH-1:0]   w_sum;
  logic               w_cout;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_res;
  logic [4:0]         w_flags;

  function automatic logic [WIDTH-1:0] shift1(input logic [3:0] sop, input logic [WIDTH-1:0] x);
    case (sop)
      OP_LSH:  shift1 = {x[WIDTH-2:0], 1'b0};
      OP_RSH:  shift1 = {1'b0, x[WIDTH-1:1]};
      default: shift1 = {x[WIDTH-1], x[WIDTH-1:1]};
    endcase
  endfunction

  assign in_ready   = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign out_valid  = (r_state == ST_DONE);
  assign result     = r_result;
  assign flags      = r_flags;
  assign w_accept   = in_valid && in_ready;
  assign w_k        = b[SHAMT_W-1:0];
  assign w_is_shift = (op == OP_LSH) || (op == OP_RSH) || (op == OP_ARSH);
  assign w_long     = w_is_shift && (w_k > SHAMT_W'(1));
  assign w_sub      = (op == OP_SUB) || (op == OP_SUBC) || (op == OP_CMP);
  // Carry-in always comes from the flag register, never from the adder output.
  assign w_cin      = ((op == OP_ADDC) || (op == OP_SUBC)) ? r_flags[FLAG_C] : 1'b0;

  alu_addsub #(.WIDTH(WIDTH)) u_addsub (
    .a    (a),
    .b    (b),
    .cin  (w_cin),
    .sub  (w_sub),
    .sum  (w_sum),
    .cout (w_cout),
    .ovf  (w_ovf)
  );

  always_comb begin
    w_res   = '0;
    w_flags = r_flags;
    case (op)
      OP_ADD, OP_ADDC, OP_SUB, OP_SUBC: begin
        w_res           = w_sum;
        w_flags[FLAG_C] = w_cout;
        w_flags[FLAG_F] = w_ovf;
        w_flags[FLAG_Z] = (w_sum == '0);
      end
      OP_CMP: begin
        w_flags[FLAG_L] = w_cout;
        w_flags[FLAG_N] = w_sum[WIDTH-1] ^ w_ovf;
        w_flags[FLAG_Z] = (a == b);
      end
      OP_AND:  w_res = a & b;
      OP_OR:   w_res = a | b;
      OP_XOR:  w_res = a ^ b;
      OP_NOT:  w_res = ~a;
      OP_MOV:  w_res = a;
      OP_LSH, OP_RSH, OP_ARSH: w_res = (w_k == '0) ? a : shift1(op, a);
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_result <= '0;
      r_flags  <= '0;
      r_cnt    <= '0;
      r_shop   <= '0;
    end else if (w_accept) begin
      if (w_long) begin
        r_work  <= shift1(op, a);
        r_cnt   <= w_k - SHAMT_W'(1);
        r_shop  <= op;
        r_state <= ST_SHIFT;
      end else begin
        r_result <= w_res;
        r_flags  <= w_flags;
        r_state  <= ST_DONE;
      end
    end else if (r_state == ST_SHIFT) begin
      // The shift performed while the counter reads 1 is the final one.
      if (r_cnt == SHAMT_W'(1)) begin
        r_result <= shift1(r_shop, r_work);
        r_cnt    <= '0;
        r_state  <= ST_DONE;
      end else begin
        r_work <= shift1(r_shop, r_work);
        r_cnt  <= r_cnt - SHAMT_W'(1);
      end
    end else if ((r_state == ST_DONE) && out_ready) begin
      r_state <= ST_IDLE;
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Directed scoreboard bench for alu_seq: stimulus pushes expectations, a monitor pops on each output transfer.
module tb_alu_seq;
  import alu_pkg::*;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [4:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;
  logic [20:0] exp_q[$];

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Present an op and hold it until accepted; optionally record its expected response.
  task automatic send(input logic [3:0] o, input logic [15:0] aa, input logic [15:0] bb,
                      input logic [15:0] er, input logic [4:0] ef, input bit push);
    bit accepted;
    accepted = 0;
    op = o; a = aa; b = bb; in_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (in_ready) begin
        accepted = 1;
        if (push) exp_q.push_back({er, ef});
        break;
      end
      sync();
    end
    if (!accepted) chk("accept_timeout", 32'd0, 32'd1);
    sync();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 60; t++) begin
      if (exp_q.size() == 0) break;
      sync();
    end
    chk("drain_queue", exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    logic [20:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("result", result, e[20:5]);
        chk("flags", flags, e[4:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int lat;
    int late;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; op = '0; a = '0; b = '0;
    repeat (2) sync();
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_result", result, 0);
    chk("rst_flags", flags, 0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    sync();

    // Carry chain: ADD wraps, ADDC picks up the registered carry.
    send(OP_ADD,  16'hFFFF, 16'h0001, 16'h0000, 5'h12, 1);
    send(OP_ADDC, 16'h0001, 16'h0000, 16'h0002, 5'h00, 1);
    send(OP_ADD,  16'h7FFF, 16'h0001, 16'h8000, 5'h04, 1);
    send(OP_SUB,  16'h8000, 16'h0001, 16'h7FFF, 5'h04, 1);
    send(OP_CMP,  16'hFFFF, 16'h0001, 16'h0000, 5'h05, 1);
    send(OP_CMP,  16'h1234, 16'h1234, 16'h0000, 5'h06, 1);
    send(OP_SUBC, 16'h0000, 16'h0001, 16'hFFFF, 5'h10, 1);
    send(OP_SUBC, 16'h0005, 16'h0002, 16'h0002, 5'h00, 1);
    send(OP_CMP,  16'h0001, 16'hFFFF, 16'h0000, 5'h08, 1);
    drain();

    // Multi-cycle arithmetic shift: latency k, in_ready low meanwhile.
    send(OP_ARSH, 16'h8000, 16'd5, 16'hFC00, 5'h08, 1);
    lat = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
      chk("in_ready_in_shift", in_ready, 0);
    end
    chk("arsh_latency", lat, 5);
    sync();

    send(OP_LSH, 16'h00A5, 16'd0, 16'h00A5, 5'h08, 1);
    @(negedge clk);
    chk("lsh0_latency", out_valid, 1);
    sync();
    send(OP_LSH,  16'h4001, 16'd1,  16'h8002, 5'h08, 1);
    send(OP_RSH,  16'h8000, 16'd3,  16'h1000, 5'h08, 1);
    send(OP_LSH,  16'h0001, 16'd15, 16'h8000, 5'h08, 1);
    send(OP_NOT,  16'h00FF, 16'h0000, 16'hFF00, 5'h08, 1);
    send(OP_MOV,  16'h1234, 16'h0000, 16'h1234, 5'h08, 1);
    send(OP_XOR,  16'hFF00, 16'h0FF0, 16'hF0F0, 5'h08, 1);
    send(4'd13,   16'h1234, 16'h5678, 16'h0000, 5'h08, 1);
    drain();

    // Back-pressure: result held, pending op accepted only at the release edge.
    out_ready = 1'b0;
    send(OP_AND, 16'h0F0F, 16'h00FF, 16'h000F, 5'h08, 1);
    op = OP_OR; a = 16'h00F0; b = 16'h000F; in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_out_valid", out_valid, 1);
      chk("hold_result", result, 16'h000F);
      chk("hold_flags", flags, 5'h08);
      chk("hold_in_ready", in_ready, 0);
      sync();
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    exp_q.push_back({16'h00FF, 5'h08});
    sync();
    in_valid = 1'b0;
    drain();

    // Reset in the middle of a long shift discards it.
    send(OP_RSH, 16'hFFFF, 16'd10, 16'h0000, 5'h00, 0);
    sync();
    rst_n = 1'b0;
    sync();
    @(negedge clk);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_flags", flags, 0);
    chk("midrst_result", result, 0);
    sync();
    rst_n = 1'b1;
    late = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) late++;
    end
    chk("no_late_result", late, 0);
    sync();

    send(OP_ADDC, 16'h0001, 16'h0001, 16'h0002, 5'h00, 1);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
